// File: rtl/fixed_point_addsub_driver_if.sv
// Bundle of the command, core and result streams around the add/sub driver.
// The master side is the driver itself; the slave side is its environment
// (upstream sequencer, add/sub core and downstream consumer).
interface fixed_point_addsub_driver_if;

  // Upstream command stream
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_sub;
  logic [7:0] i_cmd_a;
  logic [7:0] i_cmd_b;

  // Add/sub core handshake
  logic       o_core_start;
  logic       o_core_sub;
  logic [7:0] o_core_operandA;
  logic [7:0] o_core_operandB;
  logic       i_core_busy;
  logic       i_core_done;
  logic [7:0] i_core_data;
  logic       i_core_overflow;

  // Downstream result stream and status
  logic       o_res_valid;
  logic       i_res_ready;
  logic [7:0] o_res_data;
  logic       o_res_overflow;
  logic       o_res_timeout;
  logic [7:0] o_ovf_count;

  modport master (
    input  i_cmd_valid, i_cmd_sub, i_cmd_a, i_cmd_b,
    output o_cmd_ready,
    output o_core_start, o_core_sub, o_core_operandA, o_core_operandB,
    input  i_core_busy, i_core_done, i_core_data, i_core_overflow,
    output o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_ovf_count,
    input  i_res_ready
  );

  modport slave (
    output i_cmd_valid, i_cmd_sub, i_cmd_a, i_cmd_b,
    input  o_cmd_ready,
    input  o_core_start, o_core_sub, o_core_operandA, o_core_operandB,
    output i_core_busy, i_core_done, i_core_data, i_core_overflow,
    input  o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_ovf_count,
    output i_res_ready
  );

endinterface

// File: rtl/fixed_point_addsub_driver.sv
// Initiator front end for the 8-bit Q1.7 add/sub core: queues commands in a
// small FIFO, issues them one at a time with a start pulse, waits for the
// core (with a timeout guard), optionally saturates, and holds the result
// on a valid/ready stream until it is taken.
module fixed_point_addsub_driver #(
  parameter int DEPTH    = 4,     // command FIFO entries, power of two, >= 2
  parameter bit SATURATE = 1'b1,  // clamp overflowed results
  parameter int TIMEOUT  = 32     // cycles allowed in WAIT, >= 2
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  fixed_point_addsub_driver_if.master bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_t           state_q;
  state_t           state_d;

  assign fifo_full       = (fifo_count == CNT_W'(DEPTH));
  assign fifo_empty      = (fifo_count == '0);
  assign bus.o_cmd_ready = !fifo_full;
  assign push            = bus.i_cmd_valid && !fifo_full;
  // A command leaves the FIFO only when the core is free and we are idle.
  assign pop             = (state_q == IDLE) && !fifo_empty && !bus.i_core_busy;

  // Command storage: written on push, read at the head pointer.
  // NOTE: the storage array has no reset; the count and pointers alone
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.i_cmd_sub, bus.i_cmd_a, bus.i_cmd_b};
    end
  end

  // FIFO pointers and occupancy; a reset discards every queued command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_cnt;
  logic              done_ev;
  logic              timeout_ev;
  logic              res_take;

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and the per-cycle events that steer the datapath.
  // NOTE: every signal is given a default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    done_ev    = 1'b0;
    timeout_ev = 1'b0;
    res_take   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Core completion wins over a timeout landing in the same cycle.
        if (bus.i_core_done) begin
          done_ev = 1'b1;
          state_d = HOLD;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 2)) begin
          // The counter reaches TIMEOUT-1 on this edge without a done.
          timeout_ev = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_res_ready) begin
          res_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_core_start = (state_q == ISSUE);
  assign bus.o_res_valid  = (state_q == HOLD);

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  logic [7:0] core_sub_q;
  logic [7:0] core_a_q;
  logic [7:0] core_b_q;
  logic [7:0] res_data_q;
  logic       res_ovf_q;
  logic       res_timeout_q;
  logic [7:0] ovf_count_q;
  logic [7:0] sat_data;
  logic [7:0] result_data;
  cmd_t       head;

  assign head = fifo_mem[rd_ptr];

  // Overflow means the true result carries operand A's sign for both add and
  // sub, so the clamp direction follows A's sign bit.
  assign sat_data    = core_a_q[7] ? 8'h80 : 8'h7F;
  assign result_data = (SATURATE && bus.i_core_overflow) ? sat_data : bus.i_core_data;

  // Operand latch on pop: held stable from ISSUE until the FSM returns to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      core_sub_q <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
    end else if (pop) begin
      core_sub_q <= {7'd0, head.sub};
      core_a_q   <= head.a;
      core_b_q   <= head.b;
    end
  end

  // Wait-cycle counter: cleared while issuing, counts while waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Result capture on HOLD entry plus the sticky overflow counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_data_q    <= '0;
      res_ovf_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      ovf_count_q   <= '0;
    end else if (done_ev) begin
      res_data_q    <= result_data;
      res_ovf_q     <= bus.i_core_overflow;
      res_timeout_q <= 1'b0;
      if (bus.i_core_overflow && (ovf_count_q != 8'hFF)) begin
        ovf_count_q <= ovf_count_q + 8'd1;
      end
    end else if (timeout_ev) begin
      res_data_q    <= 8'h00;
      res_ovf_q     <= 1'b0;
      res_timeout_q <= 1'b1;
    end
  end

  assign bus.o_core_sub      = core_sub_q[0];
  assign bus.o_core_operandA = core_a_q;
  assign bus.o_core_operandB = core_b_q;
  assign bus.o_res_data      = res_data_q;
  assign bus.o_res_overflow  = res_ovf_q;
  assign bus.o_res_timeout   = res_timeout_q;
  assign bus.o_ovf_count     = ovf_count_q;

  // The upper bits of the sub register are constant zero; the result-take
  // event is already encoded in the state transition.
  logic unused_ok;
  assign unused_ok = ^{core_sub_q[7:1], res_take};

endmodule
